// File: rtl/uartf_core.sv
// uartf_core: full-duplex 8-bit UART with programmable divider, TX/RX FIFOs,
// optional even/odd parity and a 4-byte burst write mode.
module uartf_core #(
    parameter int TXDEPTH = 8,
    parameter int RXDEPTH = 8,
    parameter int DIVW    = 16,
    parameter int DIV_RST = 7
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [31:0]              d,
    input  logic                     wrtx,
    input  logic                     wrbaud,
    input  logic                     rd,
    input  logic                     rxd,
    output logic                     txd,
    output logic                     thre,
    output logic                     tend,
    output logic [7:0]               q,
    output logic                     dv,
    output logic                     fe,
    output logic                     pe,
    output logic                     ove,
    output logic [$clog2(TXDEPTH):0] txlevel,
    output logic [$clog2(RXDEPTH):0] rxlevel
);
    localparam int TAW = $clog2(TXDEPTH);
    localparam int RAW = $clog2(RXDEPTH);
    localparam int FOUR_I = 4;
    localparam logic [TAW:0]    TX_FULL  = TXDEPTH[TAW:0];
    localparam logic [TAW:0]    TX_FOUR  = FOUR_I[TAW:0];
    localparam logic [TAW:0]    TX_ONE   = {{TAW{1'b0}}, 1'b1};
    localparam logic [TAW:0]    TX_ZERO  = {(TAW+1){1'b0}};
    localparam logic [RAW:0]    RX_FULL  = RXDEPTH[RAW:0];
    localparam logic [RAW:0]    RX_ONE   = {{RAW{1'b0}}, 1'b1};
    localparam logic [RAW:0]    RX_ZERO  = {(RAW+1){1'b0}};
    localparam logic [DIVW-1:0] DIV_MIN  = DIVW'(3);
    localparam logic [DIVW-1:0] TMR_ONE  = {{(DIVW-1){1'b0}}, 1'b1};
    localparam logic [DIVW-1:0] TMR_ZERO = {DIVW{1'b0}};

    function automatic logic parity8(input logic [7:0] b, input logic odd);
        return (^b) ^ odd;
    endfunction

    // ---------------- configuration ----------------
    logic [DIVW-1:0] div_q;
    logic            burst_q, par_en_q, par_odd_q;
    logic [DIVW-1:0] div_eff_s;
    logic [DIVW:0]   half_m1_s;
    logic            unused_s;

    assign div_eff_s = (div_q < DIV_MIN) ? DIV_MIN : div_q;
    assign half_m1_s = (({1'b0, div_eff_s} + {{DIVW{1'b0}}, 1'b1}) >> 1) - {{DIVW{1'b0}}, 1'b1};
    assign unused_s  = ^{d[28:DIVW], half_m1_s[DIVW]};

    // divider, burst and parity configuration register
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q     <= DIV_RST[DIVW-1:0];
            burst_q   <= 1'b0;
            par_en_q  <= 1'b0;
            par_odd_q <= 1'b0;
        end else if (wrbaud) begin
            div_q     <= d[DIVW-1:0];
            burst_q   <= d[31];
            par_en_q  <= d[30];
            par_odd_q <= d[29];
        end
    end

    // ---------------- TX FIFO ----------------
    logic [7:0]     tx_mem_q [TXDEPTH];
    logic [TAW-1:0] tx_wp_q, tx_rp_q;
    logic [TAW:0]   tx_cnt_q;
    logic [TAW:0]   tx_free_s, tx_add_s;
    logic           tx_push1_s, tx_push4_s, tx_pop_s;
    logic [7:0]     tx_head_s;

    assign tx_free_s  = TX_FULL - tx_cnt_q;
    assign tx_push1_s = wrtx && !burst_q && (tx_cnt_q != TX_FULL);
    assign tx_push4_s = wrtx && burst_q && (tx_free_s >= TX_FOUR);
    assign tx_head_s  = tx_mem_q[tx_rp_q];

    // number of entries entering the TX FIFO this cycle
    always_comb begin
        tx_add_s = TX_ZERO;
        if (tx_push4_s) begin
            tx_add_s = TX_FOUR;
        end else if (tx_push1_s) begin
            tx_add_s = TX_ONE;
        end else begin
            tx_add_s = TX_ZERO;
        end
    end

    // TX FIFO storage; a burst word lands least-significant byte first
    always_ff @(posedge clk) begin
        if (tx_push4_s) begin
            for (int i = 0; i < 4; i++) begin
                tx_mem_q[tx_wp_q + TAW'(i)] <= d[8*i +: 8];
            end
        end else if (tx_push1_s) begin
            tx_mem_q[tx_wp_q] <= d[7:0];
        end
    end

    // TX FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_wp_q  <= {TAW{1'b0}};
            tx_rp_q  <= {TAW{1'b0}};
            tx_cnt_q <= TX_ZERO;
        end else begin
            tx_wp_q  <= tx_wp_q + tx_add_s[TAW-1:0];
            tx_rp_q  <= tx_rp_q + (tx_pop_s ? TX_ONE[TAW-1:0] : {TAW{1'b0}});
            tx_cnt_q <= tx_cnt_q + tx_add_s - (tx_pop_s ? TX_ONE : TX_ZERO);
        end
    end

    // ---------------- TX shifter ----------------
    typedef enum logic [2:0] {
        TX_IDLE  = 3'd0,
        TX_START = 3'd1,
        TX_DATA  = 3'd2,
        TX_PAR   = 3'd3,
        TX_STOP  = 3'd4
    } tx_state_e;

    tx_state_e       tx_state_q;
    logic [DIVW-1:0] tx_tmr_q;
    logic [2:0]      tx_bit_q;
    logic [7:0]      tx_sh_q;
    logic            tx_par_en_q, tx_par_q, txd_q;
    logic            tx_bit_end_s;

    assign tx_bit_end_s = (tx_tmr_q == TMR_ZERO);
    // next frame is fetched when idle, or at the end of a stop bit for back-to-back frames
    assign tx_pop_s = (tx_cnt_q != TX_ZERO) &&
                      ((tx_state_q == TX_IDLE) || ((tx_state_q == TX_STOP) && tx_bit_end_s));

    // TX frame sequencer; the bit timer reloads at each boundary so a new divider lands there
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q  <= TX_IDLE;
            tx_tmr_q    <= TMR_ZERO;
            tx_bit_q    <= 3'd0;
            tx_sh_q     <= 8'h00;
            tx_par_en_q <= 1'b0;
            tx_par_q    <= 1'b0;
            txd_q       <= 1'b1;
        end else begin
            case (tx_state_q)
                TX_IDLE, TX_STOP: begin
                    if ((tx_state_q == TX_STOP) && !tx_bit_end_s) begin
                        tx_tmr_q <= tx_tmr_q - TMR_ONE;
                    end else if (tx_pop_s) begin
                        tx_state_q  <= TX_START;
                        tx_tmr_q    <= div_eff_s;
                        tx_sh_q     <= tx_head_s;
                        tx_par_en_q <= par_en_q;
                        tx_par_q    <= parity8(tx_head_s, par_odd_q);
                        txd_q       <= 1'b0;
                    end else begin
                        tx_state_q <= TX_IDLE;
                        txd_q      <= 1'b1;
                    end
                end
                TX_START: begin
                    if (tx_bit_end_s) begin
                        tx_state_q <= TX_DATA;
                        tx_tmr_q   <= div_eff_s;
                        tx_bit_q   <= 3'd0;
                        txd_q      <= tx_sh_q[0];
                        tx_sh_q    <= {1'b0, tx_sh_q[7:1]};
                    end else begin
                        tx_tmr_q <= tx_tmr_q - TMR_ONE;
                    end
                end
                TX_DATA: begin
                    if (!tx_bit_end_s) begin
                        tx_tmr_q <= tx_tmr_q - TMR_ONE;
                    end else if (tx_bit_q == 3'd7) begin
                        tx_tmr_q   <= div_eff_s;
                        tx_state_q <= tx_par_en_q ? TX_PAR : TX_STOP;
                        txd_q      <= tx_par_en_q ? tx_par_q : 1'b1;
                    end else begin
                        tx_tmr_q <= div_eff_s;
                        tx_bit_q <= tx_bit_q + 3'd1;
                        txd_q    <= tx_sh_q[0];
                        tx_sh_q  <= {1'b0, tx_sh_q[7:1]};
                    end
                end
                TX_PAR: begin
                    if (tx_bit_end_s) begin
                        tx_state_q <= TX_STOP;
                        tx_tmr_q   <= div_eff_s;
                        txd_q      <= 1'b1;
                    end else begin
                        tx_tmr_q <= tx_tmr_q - TMR_ONE;
                    end
                end
                default: begin
                    tx_state_q <= TX_IDLE;
                    txd_q      <= 1'b1;
                end
            endcase
        end
    end

    assign txd     = txd_q;
    assign tend    = (tx_state_q == TX_IDLE) && (tx_cnt_q == TX_ZERO);
    assign thre    = burst_q ? (tx_free_s >= TX_FOUR) : (tx_cnt_q != TX_FULL);
    assign txlevel = tx_cnt_q;

    // ---------------- RX front end ----------------
    logic rx_s1_q, rx_s2_q, rx_s3_q;

    // two-flop synchroniser plus one delayed copy for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1_q <= 1'b1;
            rx_s2_q <= 1'b1;
            rx_s3_q <= 1'b1;
        end else begin
            rx_s1_q <= rxd;
            rx_s2_q <= rx_s1_q;
            rx_s3_q <= rx_s2_q;
        end
    end

    typedef enum logic [2:0] {
        RX_IDLE  = 3'd0,
        RX_START = 3'd1,
        RX_DATA  = 3'd2,
        RX_PAR   = 3'd3,
        RX_STOP  = 3'd4
    } rx_state_e;

    rx_state_e       rx_state_q;
    logic [DIVW-1:0] rx_tmr_q;
    logic [2:0]      rx_bit_q;
    logic [7:0]      rx_sh_q;
    logic            rx_par_en_q, rx_par_odd_q, rx_parbit_q;
    logic            rx_sample_s, rx_store_s, rx_fe_s, rx_pe_s;

    assign rx_sample_s = (rx_tmr_q == TMR_ZERO);
    assign rx_store_s  = (rx_state_q == RX_STOP) && rx_sample_s;
    assign rx_fe_s     = !rx_s2_q;
    assign rx_pe_s     = rx_par_en_q && (rx_parbit_q != parity8(rx_sh_q, rx_par_odd_q));

    // RX frame sequencer: half-bit start check, then one sample per bit period
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_q   <= RX_IDLE;
            rx_tmr_q     <= TMR_ZERO;
            rx_bit_q     <= 3'd0;
            rx_sh_q      <= 8'h00;
            rx_par_en_q  <= 1'b0;
            rx_par_odd_q <= 1'b0;
            rx_parbit_q  <= 1'b0;
        end else begin
            case (rx_state_q)
                RX_IDLE: begin
                    if (rx_s3_q && !rx_s2_q) begin
                        rx_state_q   <= RX_START;
                        rx_tmr_q     <= half_m1_s[DIVW-1:0];
                        rx_par_en_q  <= par_en_q;
                        rx_par_odd_q <= par_odd_q;
                    end
                end
                RX_START: begin
                    if (!rx_sample_s) begin
                        rx_tmr_q <= rx_tmr_q - TMR_ONE;
                    end else if (rx_s2_q) begin
                        rx_state_q <= RX_IDLE;
                    end else begin
                        rx_state_q <= RX_DATA;
                        rx_tmr_q   <= div_eff_s;
                        rx_bit_q   <= 3'd0;
                    end
                end
                RX_DATA: begin
                    if (rx_sample_s) begin
                        rx_tmr_q <= div_eff_s;
                        rx_sh_q  <= {rx_s2_q, rx_sh_q[7:1]};
                        rx_bit_q <= rx_bit_q + 3'd1;
                        if (rx_bit_q == 3'd7) begin
                            rx_state_q <= rx_par_en_q ? RX_PAR : RX_STOP;
                        end
                    end else begin
                        rx_tmr_q <= rx_tmr_q - TMR_ONE;
                    end
                end
                RX_PAR: begin
                    if (rx_sample_s) begin
                        rx_parbit_q <= rx_s2_q;
                        rx_tmr_q    <= div_eff_s;
                        rx_state_q  <= RX_STOP;
                    end else begin
                        rx_tmr_q <= rx_tmr_q - TMR_ONE;
                    end
                end
                RX_STOP: begin
                    if (rx_sample_s) begin
                        rx_state_q <= RX_IDLE;
                    end else begin
                        rx_tmr_q <= rx_tmr_q - TMR_ONE;
                    end
                end
                default: rx_state_q <= RX_IDLE;
            endcase
        end
    end

    // ---------------- RX FIFO ----------------
    logic [9:0]     rx_mem_q [RXDEPTH];
    logic [RAW-1:0] rx_wp_q, rx_rp_q;
    logic [RAW:0]   rx_cnt_q;
    logic           rx_full_s, rx_push_s, rx_pop_s, ove_q;
    logic [9:0]     rx_head_s;

    assign rx_full_s = (rx_cnt_q == RX_FULL);
    assign rx_push_s = rx_store_s && !rx_full_s;
    assign rx_pop_s  = rd && (rx_cnt_q != RX_ZERO);
    assign rx_head_s = rx_mem_q[rx_rp_q];

    // RX FIFO storage, entry = {pe, fe, byte}
    always_ff @(posedge clk) begin
        if (rx_push_s) begin
            rx_mem_q[rx_wp_q] <= {rx_pe_s, rx_fe_s, rx_sh_q};
        end
    end

    // RX FIFO pointers, occupancy and sticky overrun (set beats clear)
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_wp_q  <= {RAW{1'b0}};
            rx_rp_q  <= {RAW{1'b0}};
            rx_cnt_q <= RX_ZERO;
            ove_q    <= 1'b0;
        end else begin
            rx_wp_q  <= rx_wp_q + (rx_push_s ? RX_ONE[RAW-1:0] : {RAW{1'b0}});
            rx_rp_q  <= rx_rp_q + (rx_pop_s ? RX_ONE[RAW-1:0] : {RAW{1'b0}});
            rx_cnt_q <= rx_cnt_q + (rx_push_s ? RX_ONE : RX_ZERO) - (rx_pop_s ? RX_ONE : RX_ZERO);
            if (rx_store_s && rx_full_s) begin
                ove_q <= 1'b1;
            end else if (rx_pop_s) begin
                ove_q <= 1'b0;
            end
        end
    end

    assign dv      = (rx_cnt_q != RX_ZERO);
    assign q       = dv ? rx_head_s[7:0] : 8'h00;
    assign fe      = dv && rx_head_s[8];
    assign pe      = dv && rx_head_s[9];
    assign ove     = ove_q;
    assign rxlevel = rx_cnt_q;

endmodule

// File: tb/tb_uartf_core.sv
// Scoreboard bench for uartf_core: serial TX frames and RX FIFO entries are
// checked by independent monitors against queues filled by the stimulus.
`timescale 1ns/1ps
module tb_uartf_core;
    localparam int TXDEPTH = 8;
    localparam int RXDEPTH = 4;
    localparam int DIVW    = 16;
    localparam int DIV_RST = 7;

    logic                     clk, rst, wrtx, wrbaud, rd, rxd;
    logic [31:0]              d;
    logic                     txd, thre, tend, dv, fe, pe, ove;
    logic [7:0]               q;
    logic [$clog2(TXDEPTH):0] txlevel;
    logic [$clog2(RXDEPTH):0] rxlevel;

    logic loop_en, rx_drv, auto_rd, txmon_en;
    int   bitlen;
    int   checks, errors;
    logic [9:0] rx_exp[$];   // {pe, fe, byte}
    logic [9:0] tx_exp[$];   // {has_parity, parity_bit, byte}

    assign rxd = loop_en ? txd : rx_drv;

    uartf_core #(.TXDEPTH(TXDEPTH), .RXDEPTH(RXDEPTH), .DIVW(DIVW), .DIV_RST(DIV_RST)) dut (
        .clk(clk), .rst(rst), .d(d), .wrtx(wrtx), .wrbaud(wrbaud), .rd(rd), .rxd(rxd),
        .txd(txd), .thre(thre), .tend(tend), .q(q), .dv(dv), .fe(fe), .pe(pe), .ove(ove),
        .txlevel(txlevel), .rxlevel(rxlevel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic write_tx(input logic [31:0] w);
        @(negedge clk);
        d    = w;
        wrtx = 1'b1;
        @(posedge clk);
        #1 wrtx = 1'b0;
    endtask

    task automatic write_baud(input logic [31:0] w);
        @(negedge clk);
        d      = w;
        wrbaud = 1'b1;
        @(posedge clk);
        #1 wrbaud = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_tend(input string name, input int exp_cyc);
        int n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (tend !== 1'b1 && n < 20000);
        chk(name, n, exp_cyc);
    endtask

    task automatic wait_rx_drain(input string name);
        int n = 0;
        while ((rx_exp.size() != 0 || dv === 1'b1) && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({name, "_pending"}, rx_exp.size(), 32'd0);
        chk({name, "_dv"}, dv, 32'd0);
    endtask

    task automatic rx_bit(input logic v);
        rx_drv = v;
        repeat (bitlen) @(posedge clk);
        #1;
    endtask

    task automatic send_rx(input logic [7:0] b, input logic use_par, input logic pbit, input logic sbit);
        @(posedge clk);
        #1;
        rx_bit(1'b0);
        for (int i = 0; i < 8; i++) rx_bit(b[i]);
        if (use_par) rx_bit(pbit);
        rx_bit(sbit);
        rx_drv = 1'b1;
        cycles(2 * bitlen);
    endtask

    // RX monitor: pops the FIFO whenever enabled and an entry is presented
    initial begin : rx_mon
        logic [9:0] e;
        rd = 1'b0;
        forever begin
            @(negedge clk);
            if (auto_rd && dv === 1'b1) begin
                if (rx_exp.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rx_unexpected: got {pe,fe,q}=0x%0h, expected none", {pe, fe, q});
                end else begin
                    e = rx_exp.pop_front();
                    chk("rx_entry", {pe, fe, q}, {22'd0, e});
                end
                rd = 1'b1;
                @(posedge clk);
                #1 rd = 1'b0;
            end
        end
    end

    // TX monitor: decodes frames on txd at mid-bit
    initial begin : tx_mon
        logic [9:0] e;
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (txmon_en && txd === 1'b0) begin
                if (tx_exp.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL tx_unexpected: got frame start, expected none");
                    e = 10'h000;
                end else begin
                    e = tx_exp.pop_front();
                end
                repeat (bitlen / 2) @(negedge clk);
                chk("tx_start_bit", txd, 32'd0);
                for (int i = 0; i < 8; i++) begin
                    repeat (bitlen) @(negedge clk);
                    b[i] = txd;
                end
                if (e[9]) begin
                    repeat (bitlen) @(negedge clk);
                    chk("tx_parity_bit", txd, {31'd0, e[8]});
                end
                repeat (bitlen) @(negedge clk);
                chk("tx_stop_bit", txd, 32'd1);
                chk("tx_byte", b, {24'd0, e[7:0]});
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : main
        checks = 0; errors = 0;
        rst = 1'b1; d = 32'd0; wrtx = 1'b0; wrbaud = 1'b0;
        loop_en = 1'b0; rx_drv = 1'b1; auto_rd = 1'b0; txmon_en = 1'b0; bitlen = 8;
        cycles(5);
        rst = 1'b0;
        cycles(100);
        chk("rst_txd", txd, 32'd1);
        chk("rst_tend", tend, 32'd1);
        chk("rst_thre", thre, 32'd1);
        chk("rst_dv", dv, 32'd0);
        chk("rst_ove", ove, 32'd0);
        chk("rst_q", q, 32'd0);
        chk("rst_fe_pe", {fe, pe}, 32'd0);
        chk("rst_txlevel", txlevel, 32'd0);
        chk("rst_rxlevel", rxlevel, 32'd0);

        // single loopback frame, D=7
        loop_en = 1'b1; auto_rd = 1'b1; txmon_en = 1'b1;
        tx_exp.push_back({2'b00, 8'h41});
        rx_exp.push_back({2'b00, 8'h41});
        write_tx(32'h0000_0041);
        chk("push_txlevel", txlevel, 32'd1);
        chk("push_tend", tend, 32'd0);
        chk("push_txd_idle", txd, 32'd1);
        cycles(1);
        chk("load_txd_start", txd, 32'd0);
        chk("load_txlevel", txlevel, 32'd0);
        wait_tend("frame_len_single", 80);
        wait_rx_drain("rx_single");

        // burst word: four back-to-back frames
        write_baud(32'h8000_0007);
        tx_exp.push_back({2'b00, 8'h68}); tx_exp.push_back({2'b00, 8'h6F});
        tx_exp.push_back({2'b00, 8'h6C}); tx_exp.push_back({2'b00, 8'h61});
        rx_exp.push_back({2'b00, 8'h68}); rx_exp.push_back({2'b00, 8'h6F});
        rx_exp.push_back({2'b00, 8'h6C}); rx_exp.push_back({2'b00, 8'h61});
        write_tx(32'h616C_6F68);
        chk("burst_txlevel", txlevel, 32'd4);
        chk("burst_thre", thre, 32'd1);
        wait_tend("frame_len_burst4", 321);
        wait_rx_drain("rx_burst");

        // odd parity loopback
        write_baud(32'h6000_0007);
        tx_exp.push_back({2'b11, 8'h00});
        rx_exp.push_back({2'b00, 8'h00});
        write_tx(32'h0000_0000);
        wait_tend("frame_len_parity", 89);
        wait_rx_drain("rx_parity_ok");

        // injected bad parity, then bad stop bit
        loop_en = 1'b0;
        rx_exp.push_back({2'b10, 8'h55});
        send_rx(8'h55, 1'b1, 1'b0, 1'b1);
        wait_rx_drain("rx_bad_parity");
        rx_exp.push_back({2'b01, 8'h0F});
        send_rx(8'h0F, 1'b1, 1'b1, 1'b0);
        wait_rx_drain("rx_bad_stop");

        // overrun with RXDEPTH=4
        write_baud(32'h0000_0007);
        loop_en = 1'b1; auto_rd = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tx_exp.push_back({2'b00, k[7:0]});
            if (k <= 4) rx_exp.push_back({2'b00, k[7:0]});
        end
        for (int k = 1; k <= 5; k++) write_tx(k);
        wait_tend("frame_len_five", 397);
        cycles(10);
        chk("ovr_ove", ove, 32'd1);
        chk("ovr_rxlevel", rxlevel, 32'd4);
        chk("ovr_head", q, 32'h01);
        auto_rd = 1'b1;
        begin
            int n = 0;
            while (rxlevel == 3'd4 && n < 100) begin
                @(posedge clk);
                #1;
                n++;
            end
        end
        chk("ovr_cleared_by_rd", ove, 32'd0);
        wait_rx_drain("rx_overrun");
        chk("ovr_rxlevel_end", rxlevel, 32'd0);

        // full-ish TX FIFO, burst drop, then reset mid-frame
        write_baud(32'h0000_000F);
        bitlen = 16; loop_en = 1'b0; auto_rd = 1'b0; txmon_en = 1'b0;
        send_rx(8'h33, 1'b0, 1'b0, 1'b1);
        chk("held_rxlevel", rxlevel, 32'd1);
        for (int k = 0; k < 6; k++) write_tx(32'hA0 + k);
        chk("tx_level_five", txlevel, 32'd5);
        write_baud(32'h8000_000F);
        chk("thre_three_free", thre, 32'd0);
        write_tx(32'hDEAD_BEEF);
        chk("burst_dropped", txlevel, 32'd5);
        cycles(82);
        chk("txd_bit4_0xA0", txd, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("midrst_txd", txd, 32'd1);
        chk("midrst_txlevel", txlevel, 32'd0);
        chk("midrst_rxlevel", rxlevel, 32'd0);
        chk("midrst_dv", dv, 32'd0);
        chk("midrst_tend", tend, 32'd1);
        chk("midrst_thre", thre, 32'd1);

        // divider back at DIV_RST
        bitlen = DIV_RST + 1; txmon_en = 1'b1;
        tx_exp.push_back({2'b00, 8'h5A});
        write_tx(32'h0000_005A);
        wait_tend("frame_len_after_rst", 81);
        cycles(20);
        chk("tx_exp_drained", tx_exp.size(), 32'd0);

        // one-cycle glitch on rxd
        auto_rd = 1'b1;
        @(posedge clk);
        #1 rx_drv = 1'b0;
        @(posedge clk);
        #1 rx_drv = 1'b1;
        cycles(60);
        chk("glitch_rxlevel", rxlevel, 32'd0);
        chk("glitch_dv", dv, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
